aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 36 +++
 rtl/add_round_key.sv | 15 +
 rtl/aes_round_ctrl.sv | 152 +++++++++++++++
 tb/tb_aes_round_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round controller.
// Block/round-key widths, round counts per key size, FSM state encoding.
package aes_pkg;

  localparam int AES_BLOCK_W  = 128;
  localparam int AES_RK_IDX_W = 4;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  typedef logic [AES_BLOCK_W-1:0]  aes_block_t;
  typedef logic [AES_RK_IDX_W-1:0] aes_rk_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    KEY0,
    ROUND,
    FINAL,
    DONE
  } aes_state_e;

  // Handshake/control outputs of the controller, grouped as one word.
  typedef struct packed {
    logic        in_ready;
    logic        rk_req;
    aes_rk_idx_t rk_idx;
    logic        rf_final;
    logic        out_valid;
  } aes_ctrl_t;

  function automatic logic is_busy(input aes_state_e s);
    return (s == KEY0) || (s == ROUND) || (s == FINAL);
  endfunction

endpackage

// File: rtl/add_round_key.sv
// Bytewise XOR of a 128-bit state with a 128-bit round key.
// Purely combinational, no handshake.
module add_round_key
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state_in,
  input  logic [AES_BLOCK_W-1:0] key_in,
  output logic [AES_BLOCK_W-1:0] state_out
);

  for (genvar b = 0; b < AES_BLOCK_W / 8; b++) begin : g_byte
    assign state_out[b*8 +: 8] = state_in[b*8 +: 8] ^ key_in[b*8 +: 8];
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES encryption round sequencer around an external round function and key schedule.
// Latency NR+2 cycles from accept to out_valid with rk_valid held high; each missing rk_valid adds one.
// Backpressure: stalls on rk_valid, holds result in DONE until out_ready; AES_PERF_CNT_EN adds perf_cycles.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [AES_BLOCK_W-1:0]  in_data,
  output logic                    rk_req,
  output logic [AES_RK_IDX_W-1:0] rk_idx,
  input  logic                    rk_valid,
  input  logic [AES_BLOCK_W-1:0]  rk_data,
  output logic [AES_BLOCK_W-1:0]  rf_state,
  output logic                    rf_final,
  input  logic [AES_BLOCK_W-1:0]  rf_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AES_BLOCK_W-1:0]  out_data
`ifdef AES_PERF_CNT_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);

  localparam aes_rk_idx_t NR_IDX = AES_RK_IDX_W'(NR);

  aes_state_e  state_q, state_d;
  aes_block_t  blk_q, blk_d;
  aes_rk_idx_t round_q, round_d;
  aes_ctrl_t   ctrl;

  aes_block_t  ark_state;
  aes_block_t  ark_out;
  logic        acc_vld;

  // KEY0 whitens the captured plaintext; every later round whitens the round-function output.
  assign ark_state = (state_q == KEY0) ? blk_q : rf_result;

  add_round_key u_ark (
    .state_in  (ark_state),
    .key_in    (rk_data),
    .state_out (ark_out)
  );

  always_comb begin
    state_d       = state_q;
    blk_d         = blk_q;
    round_d       = round_q;
    ctrl          = '0;
    acc_vld       = 1'b0;

    case (state_q)
      IDLE: begin
        ctrl.in_ready = 1'b1;
        if (in_valid) begin
          acc_vld = 1'b1;
          blk_d   = in_data;
          round_d = '0;
          state_d = KEY0;
        end
      end
      KEY0: begin
        ctrl.rk_req = 1'b1;
        ctrl.rk_idx = '0;
        if (rk_valid) begin
          blk_d   = ark_out;
          round_d = aes_rk_idx_t'(1);
          state_d = (NR_IDX == aes_rk_idx_t'(1)) ? FINAL : ROUND;
        end
      end
      ROUND: begin
        ctrl.rk_req = 1'b1;
        ctrl.rk_idx = round_q;
        if (rk_valid) begin
          blk_d   = ark_out;
          round_d = round_q + aes_rk_idx_t'(1);
          if (round_d == NR_IDX) begin
            state_d = FINAL;
          end
        end
      end
      FINAL: begin
        ctrl.rk_req   = 1'b1;
        ctrl.rk_idx   = NR_IDX;
        ctrl.rf_final = 1'b1;
        if (rk_valid) begin
          blk_d   = ark_out;
          state_d = DONE;
        end
      end
      DONE: begin
        ctrl.out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      round_q <= round_d;
    end
  end

  assign in_ready  = ctrl.in_ready;
  assign rk_req    = ctrl.rk_req;
  assign rk_idx    = ctrl.rk_idx;
  assign rf_final  = ctrl.rf_final;
  assign out_valid = ctrl.out_valid;
  assign rf_state  = blk_q;
  assign out_data  = blk_q;

`ifdef AES_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Counts only cycles the block spends waiting on keys/rounds; idle and output wait are excluded.
  always_comb begin
    perf_d = perf_q;
    if (acc_vld) begin
      perf_d = '0;
    end else if (is_busy(state_q)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: FIPS-197 vectors through NR=10 and NR=14 instances,
// with key-schedule stalls, output backpressure and mid-block reset.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;
  logic         in_valid;
  logic [127:0] in_data;
  logic         rk_valid;
  logic         out_ready;

  always #5 clk = ~clk;

  // ---------------- AES reference arithmetic (environment) ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] base;
    r    = 8'h01;
    base = x;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
    logic [7:0]   t [16];
    logic [7:0]   u [16];
    logic [7:0]   v [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) t[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        u[r+4*c] = t[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
      if (fin) begin
        v[4*c] = a0; v[4*c+1] = a1; v[4*c+2] = a2; v[4*c+3] = a3;
      end else begin
        v[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        v[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        v[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        v[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = v[i];
    return o;
  endfunction

  logic [127:0] rkey10 [0:15];
  logic [127:0] rkey14 [0:15];

  task automatic expand(input logic [255:0] key, input int nk, input logic s14);
    logic [31:0] w [0:59];
    logic [31:0] tmp;
    logic [7:0]  rc;
    int          nw;
    nw = (nk == 8) ? 60 : 44;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < nw / 4; r++) begin
      if (s14) rkey14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else     rkey10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // ---------------- DUT instances and their environments ----------------
  logic         ir10, req10, fin10, ov10;
  logic [3:0]   idx10;
  logic [127:0] rfs10, rfr10, od10, rkd10;
  logic         ir14, req14, fin14, ov14;
  logic [3:0]   idx14;
  logic [127:0] rfs14, rfr14, od14, rkd14;
`ifdef AES_PERF_CNT_EN
  logic [31:0]  pc10, pc14;
`endif

  assign rkd10 = rkey10[idx10];
  assign rkd14 = rkey14[idx14];
  assign rfr10 = aes_round(rfs10, fin10);
  assign rfr14 = aes_round(rfs14, fin14);

  aes_round_ctrl #(.NR(10)) dut10 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & ~sel), .in_ready(ir10), .in_data(in_data),
    .rk_req(req10), .rk_idx(idx10), .rk_valid(rk_valid), .rk_data(rkd10),
    .rf_state(rfs10), .rf_final(fin10), .rf_result(rfr10),
    .out_valid(ov10), .out_ready(out_ready), .out_data(od10)
`ifdef AES_PERF_CNT_EN
    , .perf_cycles(pc10)
`endif
  );

  aes_round_ctrl #(.NR(14)) dut14 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & sel), .in_ready(ir14), .in_data(in_data),
    .rk_req(req14), .rk_idx(idx14), .rk_valid(rk_valid), .rk_data(rkd14),
    .rf_state(rfs14), .rf_final(fin14), .rf_result(rfr14),
    .out_valid(ov14), .out_ready(out_ready), .out_data(od14)
`ifdef AES_PERF_CNT_EN
    , .perf_cycles(pc14)
`endif
  );

  logic         m_in_ready, m_rk_req, m_rf_final, m_out_valid;
  logic [3:0]   m_rk_idx;
  logic [127:0] m_rf_state, m_out_data;
  assign m_in_ready  = sel ? ir14  : ir10;
  assign m_rk_req    = sel ? req14 : req10;
  assign m_rk_idx    = sel ? idx14 : idx10;
  assign m_rf_final  = sel ? fin14 : fin10;
  assign m_out_valid = sel ? ov14  : ov10;
  assign m_rf_state  = sel ? rfs14 : rfs10;
  assign m_out_data  = sel ? od14  : od10;
`ifdef AES_PERF_CNT_EN
  logic [31:0] m_perf;
  assign m_perf = sel ? pc14 : pc10;
`endif

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         sel14;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
    int           stall_idx;
    int           stall_len;
    int           hold;
    logic         noise;
    int           perf;
  } vec_t;

  vec_t vecs [5];

  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PTB  = 128'h3243f6a8885a308d313198a2e0370734;

  task automatic run_vec(input int v);
    vec_t         t;
    int           cyc, left, fin_cnt, nr;
    logic         stalled, done;
    logic [3:0]   snap_idx;
    logic [127:0] snap_st;
    t = vecs[v];
    sel = t.sel14;
    nr  = t.sel14 ? 14 : 10;
    expand(t.key, t.sel14 ? 8 : 4, t.sel14);
    @(negedge clk);
    chk("in_ready_idle", 128'(m_in_ready), 128'd1);
    in_valid  = 1'b1;
    in_data   = t.pt;
    rk_valid  = 1'b1;
    out_ready = 1'b0;
    cyc = 0; left = t.stall_len; fin_cnt = 0; stalled = 1'b0; done = 1'b0;
    snap_idx = '0; snap_st = '0;
    while (cyc < 60 && !done) begin
      @(negedge clk);
      cyc++;
      if (t.noise) begin
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        in_valid = 1'b0;
      end
      if (stalled) begin
        chk("stall_rk_idx", 128'(m_rk_idx), 128'(snap_idx));
        chk("stall_rf_state", m_rf_state, snap_st);
        chk("stall_rk_req", 128'(m_rk_req), 128'd1);
      end
      if (m_out_valid) begin
        done = 1'b1;
      end else begin
        if (m_rf_final) fin_cnt++;
        if (m_rk_req && int'(m_rk_idx) == t.stall_idx && left > 0) begin
          rk_valid = 1'b0;
          left--;
          snap_idx = m_rk_idx;
          snap_st  = m_rf_state;
          stalled  = 1'b1;
        end else begin
          rk_valid = 1'b1;
          stalled  = 1'b0;
        end
      end
    end
    chk("latency", 128'(cyc), 128'(t.lat));
    chk("ciphertext", m_out_data, t.ct);
    chk("final_cycles", 128'(fin_cnt), 128'(1 + ((t.stall_idx == nr) ? t.stall_len : 0)));
`ifdef AES_PERF_CNT_EN
    chk("perf_cycles", 128'(m_perf), 128'(t.perf));
`endif
    for (int h = 0; h < t.hold; h++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("hold_out_valid", 128'(m_out_valid), 128'd1);
      chk("hold_out_data", m_out_data, t.ct);
      chk("hold_in_ready", 128'(m_in_ready), 128'd0);
      chk("hold_rk_req", 128'(m_rk_req), 128'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_in_ready", 128'(m_in_ready), 128'd1);
    chk("idle_out_valid", 128'(m_out_valid), 128'd0);
`ifdef AES_PERF_CNT_EN
    chk("perf_frozen", 128'(m_perf), 128'(t.perf));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hit;
    vecs[0] = '{1'b0, {K128, 128'h0}, PT1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 12, -1, 0, 0, 1'b0, 11};
    vecs[1] = '{1'b0, {K128, 128'h0}, PT1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 15,  5, 3, 4, 1'b1, 14};
    vecs[2] = '{1'b1, K256,            PT1, 128'h8ea2b7ca516745bfeafc49904b496089, 16, -1, 0, 0, 1'b0, 15};
    vecs[3] = '{1'b0, {KB, 128'h0},    PTB, 128'h3925841d02dc09fbdc118597196a0b32, 14,  0, 2, 1, 1'b1, 13};
    vecs[4] = '{1'b1, K256,            PT1, 128'h8ea2b7ca516745bfeafc49904b496089, 17, 14, 1, 2, 1'b0, 16};

    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_data = '0; rk_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(m_in_ready), 128'd1);
    chk("rst_out_valid", 128'(m_out_valid), 128'd0);
    chk("rst_rk_req", 128'(m_rk_req), 128'd0);
    chk("rst_rk_idx", 128'(m_rk_idx), 128'd0);
    chk("rst_rf_final", 128'(m_rf_final), 128'd0);
    chk("rst_state", m_rf_state, 128'd0);
`ifdef AES_PERF_CNT_EN
    chk("rst_perf", 128'(m_perf), 128'd0);
`endif

    for (int v = 0; v < 5; v++) run_vec(v);

    // Mid-block reset at round-key index 7, then a clean block.
    sel = 1'b0;
    expand({K128, 128'h0}, 4, 1'b0);
    in_valid = 1'b1; in_data = PT1; rk_valid = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (m_rk_req && m_rk_idx == 4'd7) hit = 1'b1;
    end
    chk("reached_idx7", 128'(hit), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", 128'(m_in_ready), 128'd1);
    chk("mid_rst_out_valid", 128'(m_out_valid), 128'd0);
    chk("mid_rst_rk_req", 128'(m_rk_req), 128'd0);
    chk("mid_rst_rk_idx", 128'(m_rk_idx), 128'd0);
    chk("mid_rst_rf_final", 128'(m_rf_final), 128'd0);
    chk("mid_rst_state", m_rf_state, 128'd0);
    @(negedge clk);
    chk("post_rst_idle", 128'(m_rk_req), 128'd0);
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
